free_list_fifo_mp: RTL and testbench
====================================

// Module: free_list_fifo_mp
// PURPOSE
//  Multi-port physical-register free list for the rename stage. Grants up to ALLOC_W regs and accepts up to FREE_W
//  freed regs per cycle. Keeps NCHKPT internal head-pointer checkpoints for single-cycle branch-mispredict recovery.
//  Successor to the single-port free list; the rename table and commit/ROB free path connect to it.
// PARAMETERS
//  PHYSREG  128  number of physical registers; PREG_W = $clog2(PHYSREG)
//  AREG     32   architectural registers; DEPTH = PHYSREG-AREG (must be > 0, else $fatal at elaboration)
//  ALLOC_W  4    alloc lanes per cycle (1..DEPTH)
//  FREE_W   4    free lanes per cycle (1..DEPTH)
//  NCHKPT   8    checkpoint slots; CID_W = $clog2(NCHKPT), minimum 1
// PORTS
//  clk_i         in   1                clock
//  rst_ni        in   1                asynchronous reset, active low
//  alloc_cnt_i   in   $clog2(ALLOC_W+1) regs requested this cycle
//  alloc_gnt_o   out  1                request granted in full (all-or-nothing)
//  alloc_idx_o   out  ALLOC_W*PREG_W   lane k = fifo[head+k]; valid for lanes < alloc_cnt_i when granted
//  free_vld_i    in   FREE_W           per-lane free valid, any mask
//  free_idx_i    in   FREE_W*PREG_W    per-lane freed physreg
//  free_count_o  out  PREG_W+1         regs currently free
//  empty_o       out  1                free_count_o == 0
//  overflow_o    out  1                sticky: push would exceed DEPTH
//  chkpt_take_i  in   1                snapshot head into slot chkpt_id_i
//  chkpt_id_i    in   CID_W            slot written
//  recover_i     in   1                restore head from slot recover_id_i
//  recover_id_i  in   CID_W            slot read
//  dup_free_o    out  1                sticky double-free flag (FREE_LIST_DUP_CHECK_EN only; else tied 0)
// BEHAVIOUR
//  - Pointers head_q/tail_q run 0..2*DEPTH-1, with wrap at 2*DEPTH. RAM address is ptr mod DEPTH.
//    count = (tail_q - head_q) mod 2*DEPTH. No separate count register.
//  - Reset: fifo[k] = AREG+k, head_q = 0, tail_q = DEPTH (count = DEPTH), all checkpoint slots = 0.
//    Reset outputs: alloc_gnt_o=0, empty_o=0, free_count_o=DEPTH, overflow_o=0, dup_free_o=0.
//  - alloc_gnt_o = !recover_i && alloc_cnt_i != 0 && alloc_cnt_i <= count (combinational, same cycle).
//    On grant, head advances by alloc_cnt_i at the clock edge. Partial grants never occur.
//  - alloc_idx_o is combinational from head_q. Lanes at or past count are don't-care.
//  - Free: valid lanes are compacted in lane order, lowest lane first, and written at tail, tail+1, ...
//    tail advances by popcount(free_vld_i).
//    Frees read the pre-alloc count, so freed regs are never allocatable in the same cycle.
//  - Overflow: if count + popcount > DEPTH, the entire push is dropped and overflow_o sets. Cleared only by reset.
//  - Checkpoint: slot[chkpt_id_i] <= head after this cycle's alloc (head_d).
//    The rename bundle allocated in the same cycle is therefore pre-checkpoint state.
//  - Recover: head_q <= slot[recover_id_i]. tail is not restored; same-cycle frees still commit.
//    Same-cycle allocs are blocked (gnt=0). recover_i has priority over chkpt_take_i; a same-cycle take is ignored.
//  - Simultaneous alloc+free at count==0: no grant. The free lands and count becomes the popcount next cycle.
//  - Wrap: pointer addition is done mod 2*DEPTH. RAM lane addresses are taken mod DEPTH, so non-power-of-2 DEPTH is legal.
//  - Reset asserted mid-operation restores the full reset state asynchronously. In-flight requests are lost.
// CONFIGURATION
//  FREE_LIST_DUP_CHECK_EN defined:
//   - Keep a PHYSREG-bit in_list bitmap: set on push, cleared on grant, bits AREG.. set at reset.
//   - Recover rebuilds the bitmap from the restored window, taking up to DEPTH cycles; gnt is held 0 meanwhile.
//   - A freed index already in_list, or duplicated within one cycle, is dropped from the push and sets sticky dup_free_o.
//  FREE_LIST_DUP_CHECK_EN undefined: no bitmap, no check, dup_free_o = 0, recover is single-cycle.
// STRUCTURE
//  - Package free_list_pkg holds: preg_t, fl_ptr_t, chkpt_id_t, the DEPTH localparam function, and ptr_add(ptr, n) mod 2*DEPTH.
//  - Sub-module free_lane_compact: FREE_W-lane valid compactor producing packed indices + popcount; purely combinational.
//  - Top holds the RAM, pointers, checkpoint array, and the optional bitmap.
// TESTING
//  1 Reset, alloc_cnt=4 -> gnt=1, idx={32,33,34,35}, next free_count=92.
//  2 Drain to count=2, alloc_cnt=3 -> gnt=0, head unchanged.
//    Same cycle free_vld=4'b0101 -> count=4 next cycle.
//  3 free_vld=4'b1010 with idx {_,70,_,71} -> 70 at tail, 71 at tail+1.
//    Cycle pointers past 2*DEPTH with DEPTH=96 -> count correct across wrap.
//  4 take slot 3 with alloc 2 same cycle; alloc 8 more; recover 3 with free of 1 reg.
//    -> head = snapshot, count = prior + 8 + 1, gnt=0 that cycle.
//  5 With count=DEPTH, free 1 -> overflow_o=1, count stays DEPTH.
//    Deassert rst_ni mid-burst -> all reset values.
//  6 (DUP_CHECK_EN) free 40 while already free, or same index on two lanes -> dup_free_o=1, list contains 40 once.

Source files
------------

// File: rtl/free_list_pkg.sv
// Shared types and pointer arithmetic for the multi-port physical-register free list.
// The DEF_* values are the default configuration of free_list_fifo_mp.
package free_list_pkg;

   localparam int unsigned DEF_PHYSREG = 128;
   localparam int unsigned DEF_AREG    = 32;
   localparam int unsigned DEF_ALLOC_W = 4;
   localparam int unsigned DEF_FREE_W  = 4;
   localparam int unsigned DEF_NCHKPT  = 8;

   // Free-list capacity; 0 marks an illegal configuration.
   function automatic int unsigned fl_depth(input int unsigned physreg, input int unsigned areg);
      return (physreg > areg) ? physreg - areg : 0;
   endfunction

   localparam int unsigned DEF_DEPTH  = fl_depth(DEF_PHYSREG, DEF_AREG);
   localparam int unsigned DEF_PREG_W = $clog2(DEF_PHYSREG);
   localparam int unsigned DEF_PTR_W  = $clog2(2 * DEF_DEPTH);
   localparam int unsigned DEF_CID_W  = (DEF_NCHKPT > 1) ? $clog2(DEF_NCHKPT) : 1;

   typedef logic [DEF_PREG_W-1:0] preg_t;
   typedef logic [DEF_PTR_W-1:0]  fl_ptr_t;
   typedef logic [DEF_CID_W-1:0]  chkpt_id_t;

   // Pointer add mod 2*depth; callers keep ptr < 2*depth and n <= depth, so one subtract suffices.
   function automatic int unsigned ptr_add(input int unsigned ptr, input int unsigned n,
                                           input int unsigned depth);
      int unsigned s;
      s = ptr + n;
      if (s >= 2 * depth) s = s - 2 * depth;
      return s;
   endfunction

   // RAM address of a pointer (ptr mod depth).
   function automatic int unsigned ptr_addr(input int unsigned ptr, input int unsigned depth);
      return (ptr >= depth) ? ptr - depth : ptr;
   endfunction

endpackage

// File: rtl/free_list_fifo_mp_free_lane_compact.sv
// Combinational free-lane compactor: packs valid lanes lowest-first and counts them.
module free_lane_compact #(
   parameter int unsigned LANES = 4,
   parameter int unsigned IDX_W = 7
) (
   input  logic [LANES-1:0]               vld_i,
   input  logic [LANES*IDX_W-1:0]         idx_i,
   output logic [LANES*IDX_W-1:0]         idx_o,
   output logic [$clog2(LANES+1)-1:0]     cnt_o
);

   localparam int unsigned CNT_W = $clog2(LANES + 1);

   int unsigned pos;

   always_comb begin
      idx_o = '0;
      pos   = 0;
      for (int unsigned i = 0; i < LANES; i++) begin
         if (vld_i[i]) begin
            idx_o[pos*IDX_W +: IDX_W] = idx_i[i*IDX_W +: IDX_W];
            pos = pos + 1;
         end
      end
      cnt_o = CNT_W'(pos);
   end

endmodule

// File: rtl/free_list_fifo_mp.sv
// Multi-port physical-register free list with head checkpoints for mispredict recovery.
// Optional double-free detection is built when FREE_LIST_DUP_CHECK_EN is defined.
module free_list_fifo_mp
   import free_list_pkg::*;
#(
   parameter int unsigned PHYSREG = DEF_PHYSREG,
   parameter int unsigned AREG    = DEF_AREG,
   parameter int unsigned ALLOC_W = DEF_ALLOC_W,
   parameter int unsigned FREE_W  = DEF_FREE_W,
   parameter int unsigned NCHKPT  = DEF_NCHKPT
) (
   input  logic                                  clk_i,
   input  logic                                  rst_ni,
   input  logic [$clog2(ALLOC_W+1)-1:0]          alloc_cnt_i,
   output logic                                  alloc_gnt_o,
   output logic [ALLOC_W*$clog2(PHYSREG)-1:0]    alloc_idx_o,
   input  logic [FREE_W-1:0]                     free_vld_i,
   input  logic [FREE_W*$clog2(PHYSREG)-1:0]     free_idx_i,
   output logic [$clog2(PHYSREG):0]              free_count_o,
   output logic                                  empty_o,
   output logic                                  overflow_o,
   input  logic                                  chkpt_take_i,
   input  logic [((NCHKPT>1)?$clog2(NCHKPT):1)-1:0] chkpt_id_i,
   input  logic                                  recover_i,
   input  logic [((NCHKPT>1)?$clog2(NCHKPT):1)-1:0] recover_id_i,
   output logic                                  dup_free_o
);

   localparam int unsigned DEPTH  = fl_depth(PHYSREG, AREG);
   localparam int unsigned RAM_N  = (DEPTH > 0) ? DEPTH : 1;
   localparam int unsigned PREG_W = $clog2(PHYSREG);
   localparam int unsigned PTR_W  = $clog2(2 * RAM_N);
   localparam int unsigned AW     = (RAM_N > 1) ? $clog2(RAM_N) : 1;
   localparam int unsigned CNT_W  = PREG_W + 1;
   localparam int unsigned FCNT_W = $clog2(FREE_W + 1);

   if (DEPTH == 0) begin : g_bad_depth
      $fatal(1, "free_list_fifo_mp: PHYSREG must exceed AREG");
   end
   if (ALLOC_W < 1 || ALLOC_W > RAM_N || FREE_W < 1 || FREE_W > RAM_N) begin : g_bad_lanes
      $fatal(1, "free_list_fifo_mp: ALLOC_W and FREE_W must be in 1..DEPTH");
   end

   logic [PREG_W-1:0]         fifo_q [RAM_N];
   logic [PTR_W-1:0]          chk_q  [NCHKPT];
   logic [PTR_W-1:0]          head_q, head_d, tail_q, tail_d;
   logic                      ovf_q, ovf_d;
   int unsigned               cnt_c;
   logic                      gnt_c, push_ok_c, push_ovf_c, rebuilding_c;
   logic [ALLOC_W*PREG_W-1:0] alloc_idx_c;
   logic [FREE_W-1:0]         free_ok_c;
   logic [FREE_W*PREG_W-1:0]  cmp_idx_c;
   logic [FCNT_W-1:0]         cmp_cnt_c;

   // Occupancy straight from the pointers; they run mod 2*DEPTH so full and empty differ.
   always_comb begin
      if (tail_q >= head_q) cnt_c = 32'(tail_q) - 32'(head_q);
      else                  cnt_c = 32'(tail_q) + 2 * DEPTH - 32'(head_q);
   end

   assign gnt_c = !recover_i && !rebuilding_c && (alloc_cnt_i != '0) &&
                  (32'(alloc_cnt_i) <= cnt_c);

   for (genvar k = 0; k < ALLOC_W; k++) begin : g_lane
      assign alloc_idx_c[k*PREG_W +: PREG_W] =
         fifo_q[AW'(ptr_addr(ptr_add(32'(head_q), k, DEPTH), DEPTH))];
   end

   free_lane_compact #(
      .LANES (FREE_W),
      .IDX_W (PREG_W)
   ) u_compact (
      .vld_i (free_ok_c),
      .idx_i (free_idx_i),
      .idx_o (cmp_idx_c),
      .cnt_o (cmp_cnt_c)
   );

   // Push is all-or-nothing against the pre-alloc count.
   assign push_ovf_c = (cnt_c + 32'(cmp_cnt_c)) > DEPTH;
   assign push_ok_c  = (cmp_cnt_c != '0) && !push_ovf_c;

   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      ovf_d  = ovf_q;
      if (recover_i)  head_d = chk_q[recover_id_i];
      else if (gnt_c) head_d = PTR_W'(ptr_add(32'(head_q), 32'(alloc_cnt_i), DEPTH));
      if (push_ok_c)  tail_d = PTR_W'(ptr_add(32'(tail_q), 32'(cmp_cnt_c), DEPTH));
      if (push_ovf_c) ovf_d  = 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         head_q <= '0;
         tail_q <= PTR_W'(DEPTH);
         ovf_q  <= 1'b0;
         for (int unsigned k = 0; k < RAM_N; k++) fifo_q[k] <= PREG_W'(AREG + k);
         for (int unsigned c = 0; c < NCHKPT; c++) chk_q[c] <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         ovf_q  <= ovf_d;
         if (push_ok_c) begin
            for (int unsigned j = 0; j < FREE_W; j++) begin
               if (j < 32'(cmp_cnt_c))
                  fifo_q[AW'(ptr_addr(ptr_add(32'(tail_q), j, DEPTH), DEPTH))] <=
                     cmp_idx_c[j*PREG_W +: PREG_W];
            end
         end
         // Snapshot is post-alloc, so this cycle's rename bundle sits before the checkpoint.
         if (chkpt_take_i && !recover_i && (32'(chkpt_id_i) < NCHKPT))
            chk_q[chkpt_id_i] <= head_d;
      end
   end

`ifdef FREE_LIST_DUP_CHECK_EN
   logic [PHYSREG-1:0] in_list_q, in_list_d;
   logic [PTR_W-1:0]   scan_q, scan_d, scan_end_q, scan_end_d;
   logic               rebuild_q, rebuild_d;
   logic               dup_q, dup_d;
   logic               dup_hit_c, clash_c;

   assign rebuilding_c = rebuild_q;

   // Drop lanes already in the list or repeating an earlier kept lane this cycle.
   always_comb begin
      free_ok_c = '0;
      dup_hit_c = 1'b0;
      clash_c   = 1'b0;
      for (int unsigned i = 0; i < FREE_W; i++) begin
         clash_c = in_list_q[free_idx_i[i*PREG_W +: PREG_W]];
         for (int unsigned j = 0; j < i; j++) begin
            if (free_ok_c[j] && (free_idx_i[j*PREG_W +: PREG_W] == free_idx_i[i*PREG_W +: PREG_W]))
               clash_c = 1'b1;
         end
         if (free_vld_i[i]) begin
            if (clash_c) dup_hit_c    = 1'b1;
            else         free_ok_c[i] = 1'b1;
         end
      end
   end

   // Recover clears the bitmap and rescans the restored window one entry per cycle.
   always_comb begin
      in_list_d  = recover_i ? '0 : in_list_q;
      scan_d     = scan_q;
      scan_end_d = scan_end_q;
      rebuild_d  = rebuild_q;
      dup_d      = dup_q | dup_hit_c;
      if (recover_i) begin
         scan_d     = chk_q[recover_id_i];
         scan_end_d = tail_q;
         rebuild_d  = (chk_q[recover_id_i] != tail_q);
      end else if (rebuild_q) begin
         in_list_d[fifo_q[AW'(ptr_addr(32'(scan_q), DEPTH))]] = 1'b1;
         scan_d    = PTR_W'(ptr_add(32'(scan_q), 1, DEPTH));
         rebuild_d = (scan_d != scan_end_q);
      end
      for (int unsigned k = 0; k < ALLOC_W; k++) begin
         if (gnt_c && (k < 32'(alloc_cnt_i))) in_list_d[alloc_idx_c[k*PREG_W +: PREG_W]] = 1'b0;
      end
      for (int unsigned j = 0; j < FREE_W; j++) begin
         if (push_ok_c && (j < 32'(cmp_cnt_c))) in_list_d[cmp_idx_c[j*PREG_W +: PREG_W]] = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned b = 0; b < PHYSREG; b++) in_list_q[b] <= (b >= AREG);
         scan_q     <= '0;
         scan_end_q <= '0;
         rebuild_q  <= 1'b0;
         dup_q      <= 1'b0;
      end else begin
         in_list_q  <= in_list_d;
         scan_q     <= scan_d;
         scan_end_q <= scan_end_d;
         rebuild_q  <= rebuild_d;
         dup_q      <= dup_d;
      end
   end

   assign dup_free_o = dup_q;
`else
   assign free_ok_c    = free_vld_i;
   assign rebuilding_c = 1'b0;
   assign dup_free_o   = 1'b0;
`endif

   assign alloc_gnt_o  = gnt_c;
   assign alloc_idx_o  = alloc_idx_c;
   assign free_count_o = CNT_W'(cnt_c);
   assign empty_o      = (cnt_c == 0);
   assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_free_list_fifo_mp.sv
// Scoreboard bench for free_list_fifo_mp: the driver queues expected responses, the monitor checks them.
module tb_free_list_fifo_mp;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  alloc_cnt = '0;
   logic        gnt;
   logic [27:0] alloc_idx;
   logic [3:0]  free_vld = '0;
   logic [27:0] free_idx = '0;
   logic [7:0]  free_count;
   logic        empty, ovf, dup;
   logic        take = 1'b0, rec = 1'b0;
   logic [2:0]  take_id = '0, rec_id = '0;

   always #5 clk = ~clk;

   free_list_fifo_mp dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .alloc_cnt_i  (alloc_cnt),
      .alloc_gnt_o  (gnt),
      .alloc_idx_o  (alloc_idx),
      .free_vld_i   (free_vld),
      .free_idx_i   (free_idx),
      .free_count_o (free_count),
      .empty_o      (empty),
      .overflow_o   (ovf),
      .chkpt_take_i (take),
      .chkpt_id_i   (take_id),
      .recover_i    (rec),
      .recover_id_i (rec_id),
      .dup_free_o   (dup)
   );

   typedef struct {
      int g;   int nl;
      int i0;  int i1; int i2; int i3;
      int cnt; int ovf; int dup; int step;
   } exp_t;

   exp_t expq[$];
   int   exp_list[$];
   int   n_chk = 0, n_fail = 0, step = 0;
   int   exp_ovf = 0, exp_dup = 0;

   function automatic exp_t mk(input int g, input int nl, input int i0, input int i1,
                               input int i2, input int i3, input int cnt);
      exp_t e;
      e.g = g; e.nl = nl; e.i0 = i0; e.i1 = i1; e.i2 = i2; e.i3 = i3;
      e.cnt = cnt; e.ovf = exp_ovf; e.dup = exp_dup; e.step = 0;
      return e;
   endfunction

   function automatic int lane_exp(input exp_t e, input int k);
      case (k)
         0: return e.i0;
         1: return e.i1;
         2: return e.i2;
         default: return e.i3;
      endcase
   endfunction

   task automatic chk(input string what, input int st, input int act, input int req);
      n_chk++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s step %0d: got %0d, expected %0d", what, st, act, req);
      end
   endtask

   // One cycle of stimulus; the expected response is queued for the monitor.
   task automatic cyc(input int ac, input logic [3:0] fv, input int f0, input int f1,
                      input int f2, input int f3, input bit tk, input bit rc, input exp_t e);
      @(posedge clk); #1;
      alloc_cnt = 3'(ac);
      free_vld  = fv;
      free_idx  = {7'(f3), 7'(f2), 7'(f1), 7'(f0)};
      take = tk; take_id = 3'd3;
      rec  = rc; rec_id  = 3'd3;
      e.step = step;
      step++;
      expq.push_back(e);
   endtask

   task automatic idle(input int cnt);
      cyc(0, 4'b0000, 0, 0, 0, 0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, cnt));
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (expq.size() != 0) begin
            e = expq.pop_front();
            if (e.g >= 0) chk("gnt", e.step, int'(gnt), e.g);
            if (e.g == 1 && gnt)
               for (int k = 0; k < e.nl; k++) chk("alloc_idx", e.step, int'(alloc_idx[k*7 +: 7]), lane_exp(e, k));
            chk("free_count", e.step, int'(free_count), e.cnt);
            chk("empty", e.step, int'(empty), int'(e.cnt == 0));
            chk("overflow", e.step, int'(ovf), e.ovf);
            chk("dup_free", e.step, int'(dup), e.dup);
         end
      end
   end

   initial begin : driver
      int v[4];
      // Reset state
      idle(96);
      idle(96);
      rst_n = 1'b1;
      // Test 1: first grant from reset contents
      cyc(4, 4'b0000, 0, 0, 0, 0, 0, 0, mk(1, 4, 32, 33, 34, 35, 96));
      for (int i = 0; i < 22; i++)
         cyc(4, 4'b0000, 0, 0, 0, 0, 0, 0, mk(1, 4, 36+4*i, 37+4*i, 38+4*i, 39+4*i, 92-4*i));
      cyc(2, 4'b0000, 0, 0, 0, 0, 0, 0, mk(1, 2, 124, 125, 0, 0, 4));
      // Test 2: over-request at count 2 denied, same-cycle sparse free lands
      cyc(3, 4'b0101, 10, 0, 11, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 2));
      cyc(4, 4'b0000, 0, 0, 0, 0, 0, 0, mk(1, 4, 126, 127, 10, 11, 4));
      // Alloc + free at count 0: no grant, compacted free visible next cycle
      cyc(1, 4'b1010, 0, 70, 0, 71, 0, 0, mk(0, 0, 0, 0, 0, 0, 0));
      cyc(2, 4'b0000, 0, 0, 0, 0, 0, 0, mk(1, 2, 70, 71, 0, 0, 2));
      for (int i = 0; i < 5; i++)
         cyc(0, 4'b1111, 40+4*i, 41+4*i, 42+4*i, 43+4*i, 0, 0, mk(0, 0, 0, 0, 0, 0, 4*i));
      // Test 4: checkpoint with same-cycle alloc, then recover with a free
      cyc(2, 4'b0000, 0, 0, 0, 0, 1, 0, mk(1, 2, 40, 41, 0, 0, 20));
      cyc(4, 4'b0000, 0, 0, 0, 0, 0, 0, mk(1, 4, 42, 43, 44, 45, 18));
      cyc(4, 4'b0000, 0, 0, 0, 0, 0, 0, mk(1, 4, 46, 47, 48, 49, 14));
      cyc(4, 4'b0001, 90, 0, 0, 0, 0, 1, mk(0, 0, 0, 0, 0, 0, 10));
`ifdef FREE_LIST_DUP_CHECK_EN
      repeat (24) idle(19);
`endif
      cyc(4, 4'b0000, 0, 0, 0, 0, 0, 0, mk(1, 4, 42, 43, 44, 45, 19));
      // Steady alloc/free traffic carries both pointers past 2*DEPTH
      exp_list = '{46, 47, 48, 49, 50, 51, 52, 53, 54, 55, 56, 57, 58, 59, 90};
      for (int i = 0; i < 60; i++) begin
         for (int k = 0; k < 4; k++) v[k] = (4*i + k) % 32;
         cyc(4, 4'b1111, v[0], v[1], v[2], v[3], 0, 0,
             mk(1, 4, exp_list[0], exp_list[1], exp_list[2], exp_list[3], 15));
         repeat (4) void'(exp_list.pop_front());
         for (int k = 0; k < 4; k++) exp_list.push_back(v[k]);
      end
      // Test 5: fill to DEPTH, then one more free overflows
      for (int i = 0; i < 20; i++) begin
         cyc(0, 4'b1111, 16+4*i, 17+4*i, 18+4*i, 19+4*i, 0, 0, mk(0, 0, 0, 0, 0, 0, 15+4*i));
         for (int k = 0; k < 4; k++) exp_list.push_back(16 + 4*i + k);
      end
      cyc(0, 4'b0001, 96, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 95));
      exp_list.push_back(96);
      cyc(0, 4'b0001, 97, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 96));
      exp_ovf = 1;
      cyc(4, 4'b0000, 0, 0, 0, 0, 0, 0, mk(1, 4, exp_list[0], exp_list[1], exp_list[2], exp_list[3], 96));
      repeat (4) void'(exp_list.pop_front());
      cyc(4, 4'b0000, 0, 0, 0, 0, 0, 0, mk(1, 4, exp_list[0], exp_list[1], exp_list[2], exp_list[3], 92));
      // Asynchronous reset between edges drops the in-flight request
      @(negedge clk); #1;
      rst_n = 1'b0;
      alloc_cnt = '0;
      exp_ovf = 0;
      idle(96);
      idle(96);
      rst_n = 1'b1;
      cyc(4, 4'b0000, 0, 0, 0, 0, 0, 0, mk(1, 4, 32, 33, 34, 35, 96));
`ifdef FREE_LIST_DUP_CHECK_EN
      // Test 6: 40 already free, 33 repeated on two lanes
      cyc(0, 4'b0111, 40, 33, 33, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 92));
      exp_dup = 1;
      idle(93);
`else
      idle(92);
`endif
      idle(-1 + 1 + `ifdef FREE_LIST_DUP_CHECK_EN 93 `else 92 `endif);
      for (int t = 0; t < 10 && expq.size() != 0; t++) @(posedge clk);
      if (expq.size() != 0) chk("drain_timeout", step, expq.size(), 0);
      @(posedge clk); #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
